mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the single-cycle MIPS `computer`. It snoops the computer's data-memory write bus (`memwrite`, `dataadr`, `writedata`) and claims two word addresses. Bytes stored to the TX address are queued in a small FIFO and serialised 8N1 on `tx`. This gives programs a visible output channel that benches and boards can observe without probing internal RAM.

---
 rtl/mmio_uart_tx.sv | 162 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: snoops the CPU store bus, queues bytes written to TX_ADDR
// and serialises them 8N1 on tx. STATUS_ADDR bit 0 clears the sticky overflow.
module mmio_uart_tx #(
   parameter logic [31:0] TX_ADDR      = 32'd64,
   parameter logic [31:0] STATUS_ADDR  = 32'd65,
   parameter int unsigned DEPTH        = 8,
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   output logic [31:0] status,
   output logic        tx
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

   state_e        state_q;
   logic [CW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    sh_q;
   logic          tx_q;
   logic          overflow_q;
   logic          overflow_d;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [7:0]    mem_q [DEPTH];

   logic          fifo_empty;
   logic          fifo_full;
   logic          push_req;
   logic          push;
   logic          drop;
   logic          clr;
   logic          baud_done;
   logic          pop;
   logic [7:0]    head;
   logic          busy;
   logic          unused_bits;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign push_req = memwrite && (dataadr == TX_ADDR);
   assign push     = push_req && !fifo_full;
   assign drop     = push_req && fifo_full;
   assign clr      = memwrite && (dataadr == STATUS_ADDR) && writedata[0];

   assign baud_done = (baud_q == BAUD_LAST);
   assign pop       = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_done));
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   assign busy        = (state_q != IDLE);
   assign status      = {28'b0, overflow_q, fifo_full, fifo_empty, busy};
   assign tx          = tx_q;
   assign unused_bits = ^writedata[31:8];

   // Sticky overflow: a dropped push outranks a same-cycle clear
   always_comb begin
      overflow_d = overflow_q;
      if (clr)  overflow_d = 1'b0;
      if (drop) overflow_d = 1'b1;
   end

   // Overflow flag and FIFO pointers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         overflow_q <= overflow_d;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // FIFO storage; contents are don't-care while the slot is unoccupied
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= writedata[7:0];
   end

   // Transmit FSM: start bit, 8 data bits LSB first, stop bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               tx_q   <= 1'b1;
               baud_q <= '0;
               bit_q  <= '0;
               if (!fifo_empty) begin
                  sh_q    <= head;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_done) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= sh_q[0];
                  sh_q    <= {1'b0, sh_q[7:1]};
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     tx_q  <= sh_q[0];
                     sh_q  <= {1'b0, sh_q[7:1]};
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            STOP: begin
               if (baud_done) begin
                  baud_q <= '0;
                  bit_q  <= '0;
                  if (!fifo_empty) begin
                     sh_q    <= head;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     tx_q    <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: directed store sequence, serial decoder with a
// byte scoreboard, and cycle-exact checks of framing and status.
module tb_mmio_uart_tx;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] status;
   logic        tx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         start_q[$];

   mmio_uart_tx dut (
      .clk       (clk),
      .reset     (reset),
      .memwrite  (memwrite),
      .dataadr   (dataadr),
      .writedata (writedata),
      .status    (status),
      .tx        (tx)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Serial decoder: samples mid-bit on falling clock edges, compares bytes
   // against the scoreboard; a reset abandons a partial frame.
   int         mc    = 0;
   bit         mbusy = 1'b0;
   logic [7:0] mb;
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         mbusy = 1'b0;
      end else if (!mbusy) begin
         if (tx === 1'b0) begin
            mbusy = 1'b1;
            mc    = 1;
            start_q.push_back(cyc);
         end
      end else begin
         mc++;
         if (mc == 8) check("mon_start_bit", tx, 1'b0);
         if (mc >= 24 && mc <= 136 && ((mc - 24) % 16) == 0) mb[(mc - 24) / 16] = tx;
         if (mc == 152) begin
            check("mon_stop_bit", tx, 1'b1);
            check("mon_sb_nonempty", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check("mon_byte", mb, exp_q.pop_front());
            mbusy = 1'b0;
         end
      end
   end

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = a;
      writedata = d;
      @(negedge clk);
      memwrite  = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input logic [31:0] st);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (status === st && exp_q.size() == 0) break;
      end
      check("wait_idle_status", status, st);
      check("wait_idle_sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      int         errs;
      logic       e;
      logic [7:0] b;

      // Reset held with a store to TX_ADDR pending: nothing may be pushed
      reset     = 1'b1;
      memwrite  = 1'b1;
      dataadr   = 32'd64;
      writedata = 32'h0000_0077;
      repeat (3) begin
         @(negedge clk);
         check("rst_tx", tx, 1'b1);
         check("rst_status", status, 32'h2);
      end
      memwrite = 1'b0;
      reset    = 1'b0;
      @(negedge clk);
      check("post_rst_status", status, 32'h2);
      check("post_rst_tx", tx, 1'b1);

      // Single byte 0x41
      start_q.delete();
      b = 8'h41;
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = 32'd64;
      writedata = 32'h0C0C_0041;
      exp_q.push_back(b);
      n = cyc + 1;
      @(negedge clk);
      memwrite = 1'b0;
      check("push_status", status, 32'h0);
      check("push_tx_still_high", tx, 1'b1);
      for (int k = 1; k <= 160; k++) begin
         @(negedge clk);
         if (k <= 16)       e = 1'b0;
         else if (k <= 144) e = b[(k - 17) / 16];
         else               e = 1'b1;
         check("frame_tx", tx, e);
         if (k == 160) check("busy_last_cycle", status[0], 1'b1);
      end
      @(negedge clk);
      check("busy_drop_status", status, 32'h2);
      check("single_frames", start_q.size(), 1);
      if (start_q.size() > 0) check("start_latency", start_q[0], n + 1);
      check("single_sb_empty", exp_q.size(), 0);

      // Fill and overflow: ten back-to-back stores
      start_q.delete();
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 2)  check("pre_pop_tx", tx, 1'b1);
         if (i == 3)  check("pop_second_edge_tx", tx, 1'b0);
         if (i == 10) check("full_after_9", status[3:1], 3'b010);
         memwrite  = 1'b1;
         dataadr   = 32'd64;
         writedata = 32'(i);
         if (i <= 9) exp_q.push_back(8'(i));
      end
      @(negedge clk);
      memwrite = 1'b0;
      check("overflow_set", status[3:1], 3'b110);
      wait_idle(2000, 32'hA);
      check("fill_frames", start_q.size(), 9);
      if (start_q.size() == 9)
         for (int j = 1; j < 9; j++) check("back_to_back_gap", start_q[j] - start_q[j-1], 160);

      // Overflow clear control
      store(32'd65, 32'h0000_0000);
      check("clear_zero_no_change", status, 32'hA);
      store(32'd65, 32'h0000_0001);
      check("clear_overflow", status, 32'h2);

      // Address and strobe filtering
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = 32'd63;
      writedata = 32'h55;
      @(negedge clk);
      memwrite  = 1'b0;
      dataadr   = 32'd64;
      writedata = 32'h66;
      errs = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (status !== 32'h2 || tx !== 1'b1) errs++;
      end
      check("filter_bad_cycles", errs, 0);
      check("filter_frames", start_q.size(), 9);

      // Mid-frame reset during data bit 3 with two bytes queued
      @(negedge clk);
      memwrite  = 1'b1;
      dataadr   = 32'd64;
      writedata = 32'hA5;
      exp_q.push_back(8'hA5);
      n = cyc + 1;
      @(negedge clk);
      writedata = 32'h3C;
      exp_q.push_back(8'h3C);
      @(negedge clk);
      memwrite = 1'b0;
      while (cyc < n + 70) @(negedge clk);
      check("bit3_tx_low", tx, 1'b0);
      #2 reset = 1'b1;
      #1;
      check("midrst_tx", tx, 1'b1);
      check("midrst_status", status, 32'h2);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      errs = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (status !== 32'h2 || tx !== 1'b1) errs++;
      end
      check("post_midrst_quiet", errs, 0);
      check("post_midrst_sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
